// File: rtl/fetch_pc.sv
// Fetch-stage program counter: selects the next fetch address from reset,
// exception, stall, eret and D-stage branch/jump controls, and flags the F word.
module fetch_pc (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [1:0]  npc_op,
  input  logic        branch,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_index,
  input  logic [31:0] d_rs,
  output logic [31:0] f_pc,
  output logic        f_adel,
  output logic        f_bd,
  output logic        kill_f
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI  = 32'h0000_6FFC;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_op_e;

  npc_op_e     op;
  logic [31:0] d_pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] f_pc_plus4;
  logic [31:0] next_pc;

  assign op         = npc_op_e'(npc_op);
  assign d_pc_plus4 = d_pc + 32'd4;
  // Branch offset is a word count relative to the delay-slot address; wraps silently.
  assign br_target  = d_pc_plus4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
  assign j_target   = {d_pc_plus4[31:28], d_index, 2'b00};
  assign f_pc_plus4 = f_pc + 32'd4;

  always_comb begin
    // NOTE: next_pc gets a default before any branch of the priority chain, so no
    // path leaves it unassigned and no latch is inferred.
    next_pc = f_pc_plus4;
    if (req) begin
      next_pc = EXC_PC;
    end else if (stall) begin
      next_pc = f_pc;
    end else if (eret) begin
      next_pc = epc;
    end else begin
      case (op)
        NPC_BRANCH: if (branch) next_pc = br_target;
        NPC_JUMP:   next_pc = j_target;
        NPC_JR:     next_pc = d_rs;
        default:    next_pc = f_pc_plus4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) f_pc <= RESET_PC;
    else       f_pc <= next_pc;
  end

  // Misaligned or outside the instruction window; jr targets are not sanitised.
  assign f_adel = (f_pc[1:0] != 2'b00) || (f_pc < TEXT_LO) || (f_pc > TEXT_HI);
  assign f_bd   = !req && (op != NPC_SEQ);
  assign kill_f = eret && !stall && !req;

endmodule

// File: tb/tb_fetch_pc.sv
// Table-driven bench for fetch_pc: each row drives one cycle, checks the
// combinational flags, and queues the expected post-edge PC for the scoreboard.
module tb_fetch_pc;

  logic        clk = 1'b0;
  logic        reset, stall, req, eret, branch;
  logic [31:0] epc, d_pc, d_rs;
  logic [1:0]  npc_op;
  logic [15:0] d_imm16;
  logic [25:0] d_index;
  logic [31:0] f_pc;
  logic        f_adel, f_bd, kill_f;

  int errors = 0;
  int checks = 0;

  fetch_pc dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret),
    .epc(epc), .npc_op(npc_op), .branch(branch), .d_pc(d_pc),
    .d_imm16(d_imm16), .d_index(d_index), .d_rs(d_rs),
    .f_pc(f_pc), .f_adel(f_adel), .f_bd(f_bd), .kill_f(kill_f)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        reset, stall, req, eret, branch;
    logic [31:0] epc, d_pc, d_rs;
    logic [1:0]  npc_op;
    logic [15:0] d_imm16;
    logic [25:0] d_index;
    logic [31:0] exp_pc;
    logic        exp_bd, exp_kill;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        adel;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic adel_of(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc > 32'h6FFC);
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v.reset = 0; v.stall = 0; v.req = 0; v.eret = 0; v.branch = 0;
    v.epc = 0; v.d_pc = 0; v.d_rs = 0; v.npc_op = 2'b00;
    v.d_imm16 = 0; v.d_index = 0;
    v.exp_pc = 0; v.exp_bd = 0; v.exp_kill = 0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset = v.reset; stall = v.stall; req = v.req; eret = v.eret;
    branch = v.branch; epc = v.epc; d_pc = v.d_pc; d_rs = v.d_rs;
    npc_op = v.npc_op; d_imm16 = v.d_imm16; d_index = v.d_index;
  endtask

  // Drive on the falling edge, check flags, queue expectation, compare after the rising edge.
  task automatic run_cycle(input vec_t v, input string tag);
    exp_t e, got;
    @(negedge clk);
    drive(v);
    #1;
    check({tag, " f_bd"},   {31'b0, f_bd},   {31'b0, v.exp_bd});
    check({tag, " kill_f"}, {31'b0, kill_f}, {31'b0, v.exp_kill});
    e.pc = v.exp_pc; e.adel = adel_of(v.exp_pc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: queue empty", tag);
    end else begin
      got = sb.pop_front();
      check({tag, " f_pc"},   f_pc, got.pc);
      check({tag, " f_adel"}, {31'b0, f_adel}, {31'b0, got.adel});
    end
  endtask

  initial begin
    vec_t v;
    drive(idle());

    // Reset then sequential fetch.
    v = idle(); v.reset = 1; v.exp_pc = 32'h3000; vecs.push_back(v);
    v = idle(); v.exp_pc = 32'h3004; vecs.push_back(v);
    v = idle(); v.exp_pc = 32'h3008; vecs.push_back(v);
    v = idle(); v.exp_pc = 32'h300C; vecs.push_back(v);
    // Taken backward branch, then not-taken branch (sequential, still a delay slot).
    v = idle(); v.npc_op = 2'b01; v.branch = 1; v.d_pc = 32'h3010; v.d_imm16 = 16'hFFFC;
    v.exp_pc = 32'h3004; v.exp_bd = 1; vecs.push_back(v);
    v = idle(); v.npc_op = 2'b01; v.branch = 0; v.d_pc = 32'h3010; v.d_imm16 = 16'h0040;
    v.exp_pc = 32'h3008; v.exp_bd = 1; vecs.push_back(v);
    // j with region bits from d_pc+4.
    v = idle(); v.npc_op = 2'b10; v.d_pc = 32'h3FFC; v.d_index = 26'h0000C40;
    v.exp_pc = 32'h3100; v.exp_bd = 1; vecs.push_back(v);
    // jr targets: misaligned, above window, last legal word, below window, legal.
    v = idle(); v.npc_op = 2'b11; v.d_rs = 32'h3002; v.exp_pc = 32'h3002; v.exp_bd = 1; vecs.push_back(v);
    v = idle(); v.npc_op = 2'b11; v.d_rs = 32'h7000; v.exp_pc = 32'h7000; v.exp_bd = 1; vecs.push_back(v);
    v = idle(); v.npc_op = 2'b11; v.d_rs = 32'h6FFC; v.exp_pc = 32'h6FFC; v.exp_bd = 1; vecs.push_back(v);
    v = idle(); v.npc_op = 2'b11; v.d_rs = 32'h2FFC; v.exp_pc = 32'h2FFC; v.exp_bd = 1; vecs.push_back(v);
    v = idle(); v.npc_op = 2'b11; v.d_rs = 32'h3020; v.exp_pc = 32'h3020; v.exp_bd = 1; vecs.push_back(v);
    // Stall two cycles, then req during stall with eret/branch noise.
    v = idle(); v.stall = 1; v.exp_pc = 32'h3020; vecs.push_back(v);
    v = idle(); v.stall = 1; v.npc_op = 2'b10; v.d_index = 26'h1; v.exp_pc = 32'h3020; v.exp_bd = 1; vecs.push_back(v);
    v = idle(); v.stall = 1; v.req = 1; v.eret = 1; v.epc = 32'h3500; v.npc_op = 2'b01; v.branch = 1;
    v.exp_pc = 32'h4180; vecs.push_back(v);
    v = idle(); v.exp_pc = 32'h4184; vecs.push_back(v);
    // eret: unstalled kills F and loads epc; stalled holds with no kill.
    v = idle(); v.eret = 1; v.epc = 32'h3100; v.exp_pc = 32'h3100; v.exp_kill = 1; vecs.push_back(v);
    v = idle(); v.eret = 1; v.stall = 1; v.epc = 32'h3200; v.exp_pc = 32'h3100; vecs.push_back(v);
    // eret outranks a jump in D.
    v = idle(); v.eret = 1; v.epc = 32'h3200; v.npc_op = 2'b10; v.d_index = 26'h0000D00;
    v.exp_pc = 32'h3200; v.exp_bd = 1; v.exp_kill = 1; vecs.push_back(v);
    // Branch target wraps past 2^32.
    v = idle(); v.npc_op = 2'b01; v.branch = 1; v.d_pc = 32'hFFFF_FFF8; v.d_imm16 = 16'h0001;
    v.exp_pc = 32'h0000_0000; v.exp_bd = 1; vecs.push_back(v);
    v = idle(); v.stall = 1; v.exp_pc = 32'h0000_0000; vecs.push_back(v);
    // Reset wins over req and stall.
    v = idle(); v.reset = 1; v.stall = 1; v.req = 1; v.npc_op = 2'b11; v.d_rs = 32'h5000;
    v.exp_pc = 32'h3000; vecs.push_back(v);
    // Large forward branch offset.
    v = idle(); v.npc_op = 2'b01; v.branch = 1; v.d_pc = 32'h3000; v.d_imm16 = 16'h7FFF;
    v.exp_pc = 32'h0002_3000; v.exp_bd = 1; vecs.push_back(v);

    for (int i = 0; i < vecs.size(); i++) begin
      run_cycle(vecs[i], $sformatf("vec%0d", i));
    end

    // Hand-written: long stall holds, release resumes sequential fetch.
    v = idle(); v.reset = 1; v.exp_pc = 32'h3000; run_cycle(v, "seq_reset");
    for (int k = 0; k < 4; k++) begin
      v = idle(); v.stall = 1; v.eret = (k == 2); v.epc = 32'h3300; v.exp_pc = 32'h3000;
      run_cycle(v, $sformatf("seq_stall%0d", k));
    end
    v = idle(); v.exp_pc = 32'h3004; run_cycle(v, "seq_release");
    // req with a jump in D: exception vector wins and f_bd is forced low.
    v = idle(); v.req = 1; v.npc_op = 2'b11; v.d_rs = 32'h3040; v.exp_pc = 32'h4180;
    run_cycle(v, "seq_req_jr");

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
